// File: rtl/xorshift_burst_if.sv
// Handshake bundle between the seed/length source, xorshift_burst_gen and the FIFO write port.
// With XORSHIFT_CHKSUM_EN defined the bundle also carries the per-burst XOR checksum.
interface xorshift_burst_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 9
);
    logic              in_valid;
    logic [DATA_W-1:0] seed;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] rand_num;
    logic              busy;
    logic              done;
`ifdef XORSHIFT_CHKSUM_EN
    logic [DATA_W-1:0] chksum;

    modport master (
        output in_valid, seed, len, abort, out_ready,
        input  out_valid, rand_num, busy, done, chksum
    );
    modport slave (
        input  in_valid, seed, len, abort, out_ready,
        output out_valid, rand_num, busy, done, chksum
    );
`else
    modport master (
        output in_valid, seed, len, abort, out_ready,
        input  out_valid, rand_num, busy, done
    );
    modport slave (
        input  in_valid, seed, len, abort, out_ready,
        output out_valid, rand_num, busy, done
    );
`endif
endinterface

// File: rtl/xorshift_burst_gen.sv
// Xorshift burst generator: emits len successive xorshift words from a seed under valid/ready.
// Optional XORSHIFT_CHKSUM_EN adds a per-burst XOR checksum of the transferred words.
module xorshift_burst_gen #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SHIFT_A  = 13,
    parameter int unsigned SHIFT_B  = 17,
    parameter int unsigned SHIFT_C  = 5,
    parameter int unsigned LEN_W    = 9,
    parameter logic [31:0] ZERO_SUB = 32'h2545F491
) (
    input logic             clk,
    input logic             rst_n,
    xorshift_burst_if.slave bus_io
);
    localparam logic [DATA_W-1:0] ZeroSubW = DATA_W'(ZERO_SUB);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] seed_eff;

    function automatic logic [DATA_W-1:0] step_f(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] t0;
        logic [DATA_W-1:0] t1;
        t0 = x ^ (x << SHIFT_A);
        t1 = t0 ^ (t0 >> SHIFT_B);
        return t1 ^ (t1 << SHIFT_C);
    endfunction

    // An all-zero seed would lock the generator at zero forever.
    assign seed_eff = (bus_io.seed == '0) ? ZeroSubW : bus_io.seed;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    if (bus_io.len != '0) begin
                        state_d = StRun;
                        x_d     = step_f(seed_eff);
                        rem_d   = bus_io.len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (bus_io.abort) begin
                    state_d = StIdle;
                    rem_d   = '0;
                    done_d  = 1'b1;
                end else if (bus_io.out_ready) begin
                    if (rem_q != LEN_W'(1)) begin
                        x_d   = step_f(x_q);
                        rem_d = rem_q - LEN_W'(1);
                    end else begin
                        state_d = StIdle;
                        rem_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign bus_io.out_valid = (state_q == StRun);
    assign bus_io.busy      = (state_q == StRun);
    assign bus_io.rand_num  = (state_q == StRun) ? x_q : '0;
    assign bus_io.done      = done_q;

`ifdef XORSHIFT_CHKSUM_EN
    logic [DATA_W-1:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if (state_q == StIdle && bus_io.in_valid && bus_io.len != '0) begin
            chksum_d = '0;
        end else if (state_q == StRun && bus_io.out_ready && !bus_io.abort) begin
            chksum_d = chksum_q ^ x_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chksum_q <= '0;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign bus_io.chksum = chksum_q;
`endif
endmodule
